// File: rtl/io_uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Register offsets are word indices taken from IO_A[7:2].
package io_uart_pkg;

  localparam logic [7:0] IO_BASE     = 8'hC0;

  localparam logic [5:0] OFF_TXDATA  = 6'h00;
  localparam logic [5:0] OFF_STATUS  = 6'h01;
  localparam logic [5:0] OFF_BAUDDIV = 6'h02;

  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_BUSY  = 3;
  localparam int ST_OVF   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two so
// the pointers wrap naturally.
module io_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // Callers may request regardless of state; illegal requests are ignored here.
  assign do_push = push && (count_q != (AW+1)'(DEPTH));
  assign do_pop  = pop  && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART transmitter: IO bus decode, TX FIFO and serializer.
// Bus: a write is taken on a rising CLK with IOWriteS=1; reads are combinational.
import io_uart_pkg::*;

module io_uart_tx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 868
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IO_A,
  input  logic [1:0]  IOReadS,
  input  logic        IOWriteS,
  input  logic [31:0] IO_write,
  output logic [31:0] IO_dout,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic        sel;
  logic [5:0]  off;
  logic        wr_txdata, wr_status, wr_baud;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_head;
  logic [CW-1:0] fifo_count;

  logic        overflow_q, overflow_d;
  logic [15:0] baud_q, baud_d;

  tx_state_t   state_q, state_d;
  logic [15:0] bcnt_q, bcnt_d;
  logic [2:0]  bidx_q, bidx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [15:0] div_q, div_d;
  logic        tx_q, tx_d;

  logic [31:0] status_word;
  logic        unused_bits;

  assign sel       = (IO_A[31:24] == IO_BASE) && (IO_A[23:8] == 16'h0);
  assign off       = IO_A[7:2];
  assign wr_txdata = IOWriteS && sel && (off == OFF_TXDATA);
  assign wr_status = IOWriteS && sel && (off == OFF_STATUS);
  assign wr_baud   = IOWriteS && sel && (off == OFF_BAUDDIV);

  // Full is judged on the pre-edge count, so a same-edge pop never rescues a byte.
  assign fifo_push = wr_txdata && !fifo_full;

  io_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (fifo_push),
    .din   (IO_write[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    overflow_d = overflow_q;
    if (wr_txdata && fifo_full)              overflow_d = 1'b1;
    else if (wr_status && IO_write[ST_OVF])  overflow_d = 1'b0;

    baud_d = baud_q;
    if (wr_baud) baud_d = (IO_write[15:0] == 16'h0) ? 16'd1 : IO_write[15:0];
  end

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    bidx_d   = bidx_q;
    shreg_d  = shreg_q;
    div_d    = div_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_head;
          div_d    = baud_q;
          bcnt_d   = baud_q - 16'd1;
          state_d  = START;
        end
      end
      START: begin
        if (bcnt_q == 16'd0) begin
          bidx_d  = 3'd0;
          bcnt_d  = div_q - 16'd1;
          state_d = DATA;
        end else begin
          bcnt_d = bcnt_q - 16'd1;
        end
      end
      DATA: begin
        if (bcnt_q == 16'd0) begin
          bcnt_d = div_q - 16'd1;
          if (bidx_q == 3'd7) state_d = STOP;
          else                bidx_d  = bidx_q + 3'd1;
        end else begin
          bcnt_d = bcnt_q - 16'd1;
        end
      end
      STOP: begin
        if (bcnt_q == 16'd0) begin
          // Chain straight into the next start bit when more data is waiting.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_head;
            div_d    = baud_q;
            bcnt_d   = baud_q - 16'd1;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bcnt_d = bcnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is registered from the next state so it changes with the state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[bidx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      overflow_q <= 1'b0;
      baud_q     <= 16'(DEFAULT_DIV);
      state_q    <= IDLE;
      bcnt_q     <= 16'h0;
      bidx_q     <= 3'd0;
      shreg_q    <= 8'h0;
      div_q      <= 16'd1;
      tx_q       <= 1'b1;
    end else begin
      overflow_q <= overflow_d;
      baud_q     <= baud_d;
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      bidx_q     <= bidx_d;
      shreg_q    <= shreg_d;
      div_q      <= div_d;
      tx_q       <= tx_d;
    end
  end

  assign uart_tx = tx_q;
  assign tx_busy = (state_q != IDLE) || (fifo_count != '0);

  always_comb begin
    status_word           = 32'h0;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_EMPTY] = fifo_empty;
    status_word[ST_BUSY]  = tx_busy;
    status_word[ST_OVF]   = overflow_q;

    IO_dout = 32'h0;
    if (sel && (IOReadS != 2'b00)) begin
      case (off)
        OFF_STATUS:  IO_dout = status_word;
        OFF_BAUDDIV: IO_dout = {16'h0, baud_q};
        default:     IO_dout = 32'h0;
      endcase
    end
  end

  assign unused_bits = ^{IO_A[1:0], IO_write[31:16]};

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx: bus driver tasks push expected frames into a
// queue that an independent serial-line monitor pops and compares.
module tb_io_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] io_a;
  logic [1:0]  io_reads;
  logic        io_writes;
  logic [31:0] io_write;
  logic [31:0] io_dout;
  logic        uart_tx;
  logic        tx_busy;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int wr_cyc   = 0;
  int last_start = 0;
  int last_gap   = -1;
  int prev_end   = -1000;
  logic mon_busy = 1'b0;

  // Each entry: {divider[15:0], data[7:0]}
  logic [23:0] exp_q[$];

  io_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(868)) dut (
    .CLK      (clk),
    .RESET    (rst),
    .IO_A     (io_a),
    .IOReadS  (io_reads),
    .IOWriteS (io_writes),
    .IO_write (io_write),
    .IO_dout  (io_dout),
    .uart_tx  (uart_tx),
    .tx_busy  (tx_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    io_a      = addr;
    io_write  = data;
    io_writes = 1'b1;
    @(posedge clk);
    #1;
    wr_cyc    = cyc;
    io_writes = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [1:0] strobe, output logic [31:0] data);
    @(negedge clk);
    io_a     = addr;
    io_reads = strobe;
    #1;
    data     = io_dout;
    io_reads = 2'b00;
  endtask

  task automatic send(input logic [7:0] data, input logic [15:0] div, input bit accept);
    bus_write(32'hC000_0000, {24'h0, data});
    if (accept) exp_q.push_back({div, data});
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    bit drained = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_q.size() == 0 && !mon_busy) begin
        drained = 1;
        break;
      end
      @(negedge clk);
    end
    check(name, {31'h0, drained}, 32'h1);
  endtask

  // tx_busy must still be high n cycles after the write edge and low one cycle later.
  task automatic busy_end(input string name, input int wc, input int n);
    while (cyc < wc + n) @(negedge clk);
    check({name, "_busy_last"}, {31'h0, tx_busy}, 32'h1);
    @(negedge clk);
    check({name, "_busy_done"}, {31'h0, tx_busy}, 32'h0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [23:0] e;
    logic [7:0]  d, got;
    int          div, bitn, start_cyc;
    logic        ok, aborted, expv;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && uart_tx === 1'b0) begin
        start_cyc  = cyc;
        last_start = cyc;
        mon_busy   = 1'b1;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_frame: start bit at cycle %0d, expected no frame", cyc);
          for (int i = 0; i < 20000 && tx_busy && !rst; i++) @(negedge clk);
        end else begin
          e        = exp_q.pop_front();
          div      = int'(e[23:8]);
          d        = e[7:0];
          got      = 8'h0;
          ok       = 1'b1;
          aborted  = 1'b0;
          last_gap = start_cyc - prev_end;
          for (int k = 0; k < 10 * div; k++) begin
            if (k > 0) @(negedge clk);
            if (rst) begin
              aborted = 1'b1;
              break;
            end
            bitn = k / div;
            expv = (bitn == 0) ? 1'b0 : (bitn == 9) ? 1'b1 : d[bitn-1];
            if (bitn >= 1 && bitn <= 8 && (k % div) == div / 2) got[bitn-1] = uart_tx;
            if (uart_tx !== expv) ok = 1'b0;
          end
          if (!aborted) begin
            prev_end = start_cyc + 10 * div;
            n_checks++;
            if (!ok) begin
              n_err++;
              $display("FAIL frame: got byte %h (or bad bit timing) expected byte %h at div %0d",
                       got, d, div);
            end
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin : stimulus
    logic [31:0] rd;
    bit stayed_idle;
    int wc;

    rst = 1'b1;
    io_a = 32'h0; io_reads = 2'b00; io_writes = 1'b0; io_write = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_uart_tx", {31'h0, uart_tx}, 32'h1);
    check("reset_tx_busy", {31'h0, tx_busy}, 32'h0);
    rst = 1'b0;

    bus_read(32'hC000_0004, 2'b01, rd); check("reset_status", rd, 32'h0000_0004);
    bus_read(32'hC000_0008, 2'b10, rd); check("reset_bauddiv", rd, 32'd868);
    bus_read(32'hC000_0000, 2'b01, rd); check("txdata_reads_zero", rd, 32'h0);

    // Decode: unselected or unmapped addresses
    bus_read(32'hC000_0104, 2'b01, rd); check("unsel_read_c0000104", rd, 32'h0);
    bus_read(32'h0000_0004, 2'b01, rd); check("unsel_read_00000004", rd, 32'h0);
    bus_read(32'hC000_0004, 2'b00, rd); check("no_strobe_read", rd, 32'h0);
    bus_read(32'hC000_000B, 2'b11, rd); check("low_addr_bits_ignored", rd, 32'd868);
    bus_write(32'hC000_0100, 32'h77);
    bus_write(32'h0000_0000, 32'h77);
    bus_write(32'hC000_000C, 32'h5);
    bus_read(32'hC000_0004, 2'b01, rd); check("unsel_write_no_push", rd, 32'h0000_0004);
    bus_read(32'hC000_0008, 2'b01, rd); check("unmapped_write_ignored", rd, 32'd868);

    // Single byte at DIV=4
    bus_write(32'hC000_0008, 32'd4);
    send(8'h55, 16'd4, 1);
    wc = wr_cyc;
    busy_end("single", wc, 40);
    wait_drain("single_drain", 200);
    check("single_latency", 32'(last_start - wc), 32'd1);

    // Back-to-back frames at DIV=2
    bus_write(32'hC000_0008, 32'd2);
    send(8'hA5, 16'd2, 1);
    wc = wr_cyc;
    send(8'h0F, 16'd2, 1);
    busy_end("b2b", wc, 40);
    wait_drain("b2b_drain", 200);
    check("b2b_no_gap", 32'(last_gap), 32'd0);

    // Overflow: ten back-to-back writes, the tenth is dropped
    bus_write(32'hC000_0008, 32'd4);
    for (int i = 0; i < 10; i++) send(8'h10 + 8'(i), 16'd4, i < 9);
    bus_read(32'hC000_0004, 2'b01, rd); check("ovf_status_set", rd, 32'h0000_001A);
    bus_write(32'hC000_0004, 32'h10);
    bus_read(32'hC000_0004, 2'b01, rd); check("ovf_status_cleared", rd, 32'h0000_000A);
    wait_drain("ovf_drain", 1000);
    bus_read(32'hC000_0004, 2'b01, rd); check("ovf_after_drain", rd, 32'h0000_0004);

    // DIV=0 is stored as 1, giving a 10-cycle frame
    bus_write(32'hC000_0008, 32'd0);
    bus_read(32'hC000_0008, 2'b01, rd); check("div0_reads_1", rd, 32'd1);
    send(8'h81, 16'd1, 1);
    wc = wr_cyc;
    busy_end("div1", wc, 10);
    wait_drain("div1_drain", 100);

    // DIV change mid-frame applies to the next frame only
    bus_write(32'hC000_0008, 32'd4);
    send(8'h3C, 16'd4, 1);
    send(8'hC3, 16'd2, 1);
    repeat (5) @(negedge clk);
    bus_write(32'hC000_0008, 32'd2);
    wait_drain("divchg_drain", 300);
    check("divchg_gap", 32'(last_gap), 32'd0);

    // Asynchronous reset in the middle of DATA
    bus_write(32'hC000_0008, 32'd4);
    send(8'h00, 16'd4, 1);
    wc = wr_cyc;
    send(8'h00, 16'd4, 1);
    while (cyc < wc + 10) @(negedge clk);
    check("pre_reset_line_low", {31'h0, uart_tx}, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("async_reset_uart_tx", {31'h0, uart_tx}, 32'h1);
    check("async_reset_busy", {31'h0, tx_busy}, 32'h0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus_read(32'hC000_0004, 2'b01, rd); check("post_reset_status", rd, 32'h0000_0004);
    bus_read(32'hC000_0008, 2'b01, rd); check("post_reset_bauddiv", rd, 32'd868);
    stayed_idle = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) stayed_idle = 0;
    end
    check("post_reset_no_frame", {31'h0, stayed_idle}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
